serial_adder: RTL

//   Bit-serial WIDTH-bit adder: one structuralFullAdder plus a carry flop, one operand bit per clock, LSB first.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/structuralFullAdder.sv | 23 ++
 rtl/serial_adder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e    : controller states (IDLE -> RUN -> DONE -> IDLE)
//   cnt_width(): bit-count register width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // At least one bit wide, so that WIDTH=1 still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/structuralFullAdder.sv
// Single-bit full adder, built from gate-level terms.
//   a, b, carryin : addend bits and incoming carry
//   sum           : a ^ b ^ carryin
//   carryout      : majority(a, b, carryin)
module structuralFullAdder (
  output logic sum,
  output logic carryout,
  input  logic a,
  input  logic b,
  input  logic carryin
);

  logic ab_x;
  logic ab_and;
  logic xc_and;

  assign ab_x     = a ^ b;
  assign ab_and   = a & b;
  assign xc_and   = ab_x & carryin;
  assign sum      = ab_x ^ carryin;
  assign carryout = ab_and | xc_and;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
// one operand bit per clock, LSB first.
//   clk       : clock, rising edge
//   resetn    : synchronous active-low reset
//   start     : request, only sampled in IDLE
//   a, b      : operands, captured on accepted start
//   carryin   : initial carry, captured on accepted start
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse, result valid
//   sum       : result, held until the next completion
//   carryout  : final carry, held like sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic             fa_sum;
  logic             fa_co;
  logic [WIDTH-1:0] s_next;

  structuralFullAdder u_fa (
    .sum      (fa_sum),
    .carryout (fa_co),
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .carryin  (c_q)
  );

  // New bit enters at the MSB; shifting the concatenation keeps this
  // expression legal for WIDTH=1, where it reduces to just fa_sum.
  assign s_next = WIDTH'({fa_sum, s_sh_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = carryin;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_co;
        s_sh_d = s_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = s_next;
          co_d    = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = co_q;

endmodule
